// File: rtl/commutator_n_to_1.sv
// commutator_n_to_1: registered N-to-1 channel commutator.
// Static mode selects one channel by an (optionally bit-reversed) select code;
// scan mode walks round-robin through an enable mask with a programmable dwell.
module commutator_n_to_1 #(
    parameter int unsigned N_CH    = 8,
    parameter int unsigned W       = 1,
    parameter int unsigned SEL_W   = 3,
    parameter bit          BIT_REV = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH*W-1:0]   d,
    input  logic [SEL_W-1:0]    sel,
    input  logic                mode,
    input  logic [N_CH-1:0]     ch_mask,
    input  logic [7:0]          dwell,
    output logic [W-1:0]        out,
    output logic [SEL_W-1:0]    out_ch,
    output logic                out_valid,
    output logic                frame_start
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STATIC = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_restart;

    logic [SEL_W-1:0]   w_idx;
    logic               w_idx_ok;
    logic [W-1:0]       w_idx_data;

    logic               w_mask_any;
    logic [SEL_W-1:0]   w_lowest;
    logic [SEL_W-1:0]   w_above;
    logic               w_found_above;
    logic               w_cur_en;

    logic               w_restart;
    logic               w_adv;
    logic [SEL_W-1:0]   w_tgt;
    logic               w_tgt_fs;
    logic [W-1:0]       w_tgt_data;

    // Static decode: optional bit reversal of sel, legality check, channel pick
    always_comb begin
        w_idx      = sel;
        w_idx_ok   = 1'b0;
        w_idx_data = '0;
        if (BIT_REV) begin
            for (int b = 0; b < int'(SEL_W); b++) begin
                w_idx[b] = sel[int'(SEL_W) - 1 - b];
            end
        end
        for (int k = 0; k < int'(N_CH); k++) begin
            if (w_idx == SEL_W'(k)) begin
                w_idx_ok   = 1'b1;
                w_idx_data = d[k*W +: W];
            end
        end
    end

    // Mask search: lowest enabled channel, first enabled channel above the pointer
    always_comb begin
        w_mask_any    = |ch_mask;
        w_lowest      = '0;
        w_above       = '0;
        w_found_above = 1'b0;
        w_cur_en      = 1'b0;
        for (int k = int'(N_CH) - 1; k >= 0; k--) begin
            if (ch_mask[k]) begin
                w_lowest = SEL_W'(k);
                if (SEL_W'(k) > r_ptr) begin
                    w_above       = SEL_W'(k);
                    w_found_above = 1'b1;
                end
            end
            if (r_ptr == SEL_W'(k)) begin
                w_cur_en = ch_mask[k];
            end
        end
    end

    // Scan step: restart at lowest channel, advance (dwell expired or channel dropped), or hold
    always_comb begin
        w_restart  = (r_state != ST_SCAN) | r_restart;
        w_adv      = ~w_cur_en | (r_cnt >= dwell);
        w_tgt      = r_ptr;
        w_tgt_fs   = 1'b0;
        w_tgt_data = '0;
        if (w_restart) begin
            w_tgt    = w_lowest;
            w_tgt_fs = 1'b1;
        end else if (w_adv) begin
            w_tgt    = w_found_above ? w_above : w_lowest;
            w_tgt_fs = ~w_found_above;
        end
        for (int k = 0; k < int'(N_CH); k++) begin
            if (w_tgt == SEL_W'(k)) begin
                w_tgt_data = d[k*W +: W];
            end
        end
    end

    // Mode FSM with registered outputs; sampled mode drives the outputs on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_restart   <= 1'b0;
            out         <= '0;
            out_ch      <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state     <= mode ? ST_SCAN : ST_STATIC;
                    r_restart   <= 1'b1;
                    out         <= '0;
                    out_ch      <= '0;
                    out_valid   <= 1'b0;
                    frame_start <= 1'b0;
                end
                default: begin
                    if (!mode) begin
                        r_state     <= ST_STATIC;
                        r_restart   <= 1'b1;
                        out         <= w_idx_ok ? w_idx_data : '0;
                        out_ch      <= w_idx_ok ? w_idx : '0;
                        out_valid   <= w_idx_ok;
                        frame_start <= 1'b0;
                    end else if (!w_mask_any) begin
                        r_state     <= ST_SCAN;
                        r_restart   <= 1'b1;
                        out         <= '0;
                        out_ch      <= '0;
                        out_valid   <= 1'b0;
                        frame_start <= 1'b0;
                    end else begin
                        r_state     <= ST_SCAN;
                        r_restart   <= 1'b0;
                        r_ptr       <= w_tgt;
                        r_cnt       <= (w_restart || w_adv) ? '0 : r_cnt + CNT_W'(1);
                        out         <= w_tgt_data;
                        out_ch      <= w_tgt;
                        out_valid   <= 1'b1;
                        frame_start <= w_tgt_fs;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commutator_n_to_1.sv
// Bench for commutator_n_to_1: two instances (8ch bit-reversed, 5ch natural),
// directed scenarios with literal expectations plus randomized traffic, all
// compared every cycle against a list-based behavioural model.
module tb_commutator_n_to_1;

    typedef struct {
        int st;     // 0 idle, 1 static, 2 scan
        bit rs;     // scan must (re)start at lowest enabled channel
        int ptr;
        int cnt;
        int out;
        int och;
        bit v;
        bit fs;
    } mdl_t;

    logic        clk;
    logic        rst;
    logic [31:0] d8;
    logic [19:0] d5;
    logic [2:0]  sel;
    logic        mode;
    logic [7:0]  mask;
    logic [7:0]  dwell;
    logic [3:0]  out8, out5;
    logic [2:0]  och8, och5;
    logic        v8, v5, fs8, fs5;

    int   total = 0;
    int   bad   = 0;
    mdl_t m8, m5;

    commutator_n_to_1 #(.N_CH(8), .W(4), .SEL_W(3), .BIT_REV(1'b1)) dut8 (
        .clk(clk), .rst(rst), .d(d8), .sel(sel), .mode(mode), .ch_mask(mask),
        .dwell(dwell), .out(out8), .out_ch(och8), .out_valid(v8), .frame_start(fs8)
    );

    commutator_n_to_1 #(.N_CH(5), .W(4), .SEL_W(3), .BIT_REV(1'b0)) dut5 (
        .clk(clk), .rst(rst), .d(d5), .sel(sel), .mode(mode), .ch_mask(mask[4:0]),
        .dwell(dwell), .out(out5), .out_ch(och5), .out_valid(v5), .frame_start(fs5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.st = 0; m.rs = 0; m.ptr = 0; m.cnt = 0;
        m.out = 0; m.och = 0; m.v = 0; m.fs = 0;
        return m;
    endfunction

    // One clock edge of the commutator, expressed over the list of enabled channels
    function automatic mdl_t mdl_edge(mdl_t m, int nch, bit brev, logic [31:0] dv,
                                      int s, bit md, int msk, int dw);
        mdl_t n;
        int   en[$];
        int   idx;
        int   pos;
        n    = m;
        n.fs = 0;
        if (m.st == 0) begin
            n.st = md ? 2 : 1; n.rs = 1; n.out = 0; n.och = 0; n.v = 0;
            return n;
        end
        if (!md) begin
            idx  = brev ? (((s & 1) << 2) | (s & 2) | ((s >> 2) & 1)) : s;
            n.st = 1; n.rs = 1;
            if (idx < nch) begin
                n.out = int'((dv >> (4 * idx)) & 32'hF); n.och = idx; n.v = 1;
            end else begin
                n.out = 0; n.och = 0; n.v = 0;
            end
            return n;
        end
        n.st = 2;
        for (int k = 0; k < nch; k++) if (msk[k]) en.push_back(k);
        if (en.size() == 0) begin
            n.out = 0; n.och = 0; n.v = 0; n.rs = 1;
            return n;
        end
        if (m.st == 1 || m.rs) begin
            n.ptr = en[0]; n.cnt = 0; n.fs = 1;
        end else begin
            pos = -1;
            foreach (en[i]) if (en[i] == m.ptr) pos = i;
            if (pos < 0) begin
                n.ptr = -1;
                foreach (en[i]) if (n.ptr < 0 && en[i] > m.ptr) n.ptr = en[i];
                if (n.ptr < 0) begin n.ptr = en[0]; n.fs = 1; end
                n.cnt = 0;
            end else if (m.cnt >= dw) begin
                if (pos + 1 == en.size()) begin n.ptr = en[0]; n.fs = 1; end
                else n.ptr = en[pos + 1];
                n.cnt = 0;
            end else begin
                n.cnt = m.cnt + 1;
            end
        end
        n.rs  = 0;
        n.out = int'((dv >> (4 * n.ptr)) & 32'hF);
        n.och = n.ptr;
        n.v   = 1;
        return n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("out8",   int'(out8), m8.out);
        chk("och8",   int'(och8), m8.och);
        chk("valid8", int'(v8),   int'(m8.v));
        chk("fs8",    int'(fs8),  int'(m8.fs));
        chk("out5",   int'(out5), m5.out);
        chk("och5",   int'(och5), m5.och);
        chk("valid5", int'(v5),   int'(m5.v));
        chk("fs5",    int'(fs5),  int'(m5.fs));
    endtask

    task automatic step();
        @(posedge clk);
        m8 = mdl_edge(m8, 8, 1'b1, d8, int'(sel), mode, int'(mask), int'(dwell));
        m5 = mdl_edge(m5, 5, 1'b0, {12'h0, d5}, int'(sel), mode, int'(mask), int'(dwell));
        #1;
        check_all();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        m8 = mdl_reset();
        m5 = mdl_reset();
        check_all();
        chk("rst_async_valid8", int'(v8), 0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int rev_out[8] = '{1, 5, 3, 7, 2, 6, 4, 8};
        int rev_ch[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
        int seq_ch[4]  = '{0, 2, 5, 7};
        int r;

        rst = 1'b0; mode = 1'b0; sel = '0; mask = '0; dwell = '0; d8 = '0; d5 = '0;
        m8 = mdl_reset(); m5 = mdl_reset();
        #2;
        pulse_reset();

        // static decode sweep: channel k carries k+1
        for (int k = 0; k < 8; k++) d8[k*4 +: 4] = 4'(k + 1);
        for (int k = 0; k < 5; k++) d5[k*4 +: 4] = 4'(k + 1);
        step();
        chk("idle_valid8", int'(v8), 0);
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            step();
            chk("rev_out", int'(out8), rev_out[s]);
            chk("rev_ch",  int'(och8), rev_ch[s]);
            if (s == 6) begin
                chk("illegal_valid5", int'(v5),   0);
                chk("illegal_out5",   int'(out5), 0);
            end
        end

        // sparse scan 0,2,5,7 with dwell 2
        mask = 8'hA5; dwell = 8'd2; mode = 1'b1;
        for (int i = 0; i < 25; i++) begin
            d8 = $urandom; d5 = 20'($urandom);
            step();
            chk("scan_ch", int'(och8), seq_ch[(i / 3) % 4]);
            chk("scan_fs", int'(fs8), (i % 12 == 0) ? 1 : 0);
        end

        // mask edits: drop current channel mid-dwell, empty mask, restore
        step();
        mask = 8'hA4;
        step();
        chk("drop_next_ch", int'(och8), 2);
        step();
        mask = 8'h00;
        step();
        chk("empty_valid", int'(v8), 0);
        step();
        mask = 8'hA5;
        step();
        chk("resume_ch", int'(och8), 0);
        chk("resume_fs", int'(fs8), 1);
        step();

        // reset in the middle of a dwell
        pulse_reset();
        step();
        chk("rst_idle_valid", int'(v8), 0);
        step();
        chk("rst_resume_ch", int'(och8), 0);
        chk("rst_resume_fs", int'(fs8), 1);

        // single enabled channel, dwell 1: frame pulse every 2 cycles
        mask = 8'h10; dwell = 8'd1;
        for (int i = 0; i < 6; i++) step();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            d8  = $urandom;
            d5  = 20'($urandom);
            sel = 3'($urandom);
            if ($urandom_range(0, 24) == 0) mode = ~mode;
            r = int'($urandom_range(0, 11));
            if (r == 0)      mask = 8'h00;
            else if (r < 3)  mask = 8'($urandom);
            else if (r == 3) mask = 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) dwell = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0) pulse_reset();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commutator_n_to_1.md
# commutator_n_to_1

- Parametrised, registered N-to-1 channel commutator. Successor to the combinational 8-to-1 multiplexer.
- Two modes:
  - **Static:** selects one W-bit channel by an external select code.
  - **Scan:** steps round-robin through an enable mask, holding each channel for a programmable dwell time.
- Sits between channel sources and the downstream 5-to-3 commutation stage. Supplies the data word, its channel index and a frame marker.

## Interface

Parameters:

- `N_CH`, 8, number of input channels (2..16).
- `W`, 1, width of each channel in bits.
- `SEL_W`, 3, select and index width. Must satisfy 2**SEL_W >= N_CH.
- `BIT_REV`, 1:
  - 1: `sel` is decoded bit-reversed, so `sel[0]` is the MSB. This is the legacy control encoding: 3'b100 selects channel 1.
  - 0: natural binary.

Ports:

- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `d` input N_CH*W: packed channel data. Channel k occupies `d[k*W +: W]`.
- `sel` input SEL_W: static-mode select code.
- `mode` input 1: 0 = static, 1 = scan.
- `ch_mask` input N_CH: scan-mode enable; bit k enables channel k.
- `dwell` input 8: scan-mode hold time. Each channel is output for dwell+1 cycles.
- `out` output W: selected channel data, registered.
- `out_ch` output SEL_W: natural-binary index of the channel currently on `out`.
- `out_valid` output 1: `out` carries a legal, enabled channel.
- `frame_start` output 1: one-cycle pulse on the first cycle of each scan frame.

## Operation

- **Decode, static mode.** idx = BIT_REV ? bit-reverse(`sel`) : `sel`.
  - idx < N_CH: `out` <= channel idx, `out_ch` <= idx, `out_valid` <= 1.
  - idx >= N_CH: `out` <= 0, `out_ch` <= 0, `out_valid` <= 0.
  - `ch_mask` and `dwell` are ignored. `frame_start` = 0.
- **States:** IDLE, STATIC, SCAN.
  - IDLE, after reset:
    - `mode`=0 → STATIC.
    - `mode`=1 → SCAN, starting at the lowest set bit of `ch_mask`.
  - STATIC:
    - `mode`=1 → SCAN, starting at the lowest enabled channel with the dwell counter = 0.
  - SCAN:
    - `mode`=0 → STATIC.
  - A mode change is sampled on the clock edge. The new mode drives `out` in the same cycle it is sampled.
- **Scan pointer and dwell counter.**
  - The counter increments each cycle.
  - When the counter equals `dwell`:
    - The pointer advances to the next set bit of `ch_mask` above the current pointer.
    - With no set bit above, it wraps to the lowest set bit.
    - The counter clears to 0.
  - dwell=0 advances every cycle.
- **frame_start.** Asserted together with the first output word of each frame, on:
  - entry to SCAN;
  - each pointer wrap;
  - the single-channel case below.
- **Single enabled channel.**
  - The pointer stays on that channel.
  - `frame_start` pulses every dwell+1 cycles.
- **Mask changes in scan mode.**
  - **Current channel disabled:** the pointer moves to the next enabled channel on the next edge, regardless of the counter. The counter clears.
  - **Mask becomes all-zero:**
    - `out` = 0, `out_valid` = 0, `frame_start` = 0.
    - The pointer holds.
    - When any bit sets, scan resumes from the lowest set bit with `frame_start`.
- **Dwell changes.** A new `dwell` takes effect at the next comparison. If the counter already exceeds the new value, the pointer advances on the next edge.
- **Data tracking.** Data is sampled every cycle. `out` tracks `d` of the current channel even while dwelling.

## Timing

- **Reset values:** `out`=0, `out_ch`=0, `out_valid`=0, `frame_start`=0. Pointer = 0, counter = 0, state = IDLE.
- **Reset behaviour:** takes effect immediately. It aborts a dwell in progress.
- **Static mode latency:** 1 cycle from a change on `d`/`sel` to `out`.
- **Scan mode:** 1 cycle from pointer update to `out`. `out_ch` and `out_valid` are aligned with `out`.
- **Sequence after reset release** (`mode`=1, `ch_mask`≠0, `dwell`=D):
  - first edge: IDLE → SCAN;
  - second edge: first valid word with `frame_start`=1;
  - each channel is then held for D+1 cycles.
- **Simultaneous events:** a mode change and a mask change on the same edge resolve with the mode change first, then mask rules.

## Test plan

- **Reset mid-scan.** Assert `rst` during dwell → all outputs 0 asynchronously. After release, scan restarts at the lowest enabled channel with `frame_start`=1.
- **Static decode, BIT_REV=1, N_CH=8, W=4.** `d` channel k = k+1; `sel` swept 0..7 → `out` = 1,5,3,7,2,6,4,8 one cycle later. `out_ch` = 0,4,2,6,1,5,3,7.
- **Static illegal index, N_CH=5, BIT_REV=0.** `sel`=6 → `out`=0, `out_valid`=0.
- **Scan with sparse mask.** `ch_mask`=8'b1010_0101, `dwell`=2 → `out_ch` sequence 0,2,5,7, each held 3 cycles. `frame_start` pulses every 12 cycles, aligned with channel 0.
- **Mask edits in scan.**
  - Clear the current channel's bit mid-dwell → the next enabled channel appears 1 cycle later.
  - Set `ch_mask`=0 → `out_valid`=0.
  - Restore the mask → resume at the lowest set bit with `frame_start`.
